// File: rtl/rx_stream_arbiter_pkg.sv
// Shared types and constants for the SMI RX stream arbiter: FSM states, channel IDs, widths.
package rx_stream_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_WAIT = 2'd2,
    ST_SEND = 2'd3
  } state_e;

  localparam logic CH_09 = 1'b0;
  localparam logic CH_24 = 1'b1;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;

  // Saturating increment for the per-grant word counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                               input logic [CNT_W-1:0] lim);
    logic [CNT_W-1:0] res;
    if (val >= lim) begin
      res = lim;
    end else begin
      res = val + 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rx_stream_arbiter_rr_arb2.sv
// Combinational two-way arbiter: round-robin with a word quota, or ch0-wins fixed priority.
module rr_arb2
  import rx_stream_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       cnt_full,
  input  logic       fixed_prio,
  output logic       gnt,
  output logic       gnt_valid
);

  // Grant selection; with no requester the last grant is held.
  always_comb begin
    gnt       = last_grant;
    gnt_valid = 1'b0;
    case (req)
      2'b01: begin
        gnt       = CH_09;
        gnt_valid = 1'b1;
      end
      2'b10: begin
        gnt       = CH_24;
        gnt_valid = 1'b1;
      end
      2'b11: begin
        gnt_valid = 1'b1;
        if (fixed_prio) begin
          gnt = CH_09;
        end else if (cnt_full) begin
          gnt = ~last_grant;
        end else begin
          gnt = last_grant;
        end
      end
      default: begin
        gnt       = last_grant;
        gnt_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rx_stream_arbiter.sv
// Shares the SMI RX byte path between two LVDS RX FIFOs: pops 32-bit words from the granted
// channel and serialises them MSB-first as bytes under a valid/ready handshake.
module rx_stream_arbiter
  import rx_stream_arbiter_pkg::*;
#(
  parameter int unsigned WORDS_PER_GRANT = 4
) (
  input  logic              i_sys_clk,
  input  logic              i_rst_b,
  input  logic [1:0]        i_chan_en,
  input  logic              i_fixed_prio,
  input  logic              i_ch0_empty,
  output logic              o_ch0_pop,
  input  logic [WORD_W-1:0] i_ch0_data,
  input  logic              i_ch1_empty,
  output logic              o_ch1_pop,
  input  logic [WORD_W-1:0] i_ch1_data,
  output logic [BYTE_W-1:0] o_smi_data,
  output logic              o_smi_valid,
  input  logic              i_smi_ready,
  output logic              o_smi_sof,
  output logic              o_smi_chan,
  output logic              o_busy
);

  state_e             state_r;
  state_e             state_s;
  logic               grant_r;
  logic [CNT_W-1:0]   grant_cnt_r;
  logic [WORD_W-1:0]  shreg_r;
  logic [1:0]         byte_idx_r;

  logic [1:0]         req_s;
  logic               cnt_full_s;
  logic               arb_gnt_s;
  logic               arb_valid_s;
  logic               accept_s;
  logic               last_byte_s;
  logic               arb_point_s;
  logic               arb_take_s;

  assign req_s       = i_chan_en & {~i_ch1_empty, ~i_ch0_empty};
  assign cnt_full_s  = (grant_cnt_r >= 4'(WORDS_PER_GRANT));
  assign accept_s    = (state_r == ST_SEND) & i_smi_ready;
  assign last_byte_s = accept_s & (byte_idx_r == 2'd3);
  assign arb_point_s = (state_r == ST_IDLE) | last_byte_s;
  assign arb_take_s  = arb_point_s & arb_valid_s;

  rr_arb2 u_arb (
    .req        (req_s),
    .last_grant (grant_r),
    .cnt_full   (cnt_full_s),
    .fixed_prio (i_fixed_prio),
    .gnt        (arb_gnt_s),
    .gnt_valid  (arb_valid_s)
  );

  // Next-state logic for the pop/wait/send sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (arb_valid_s) begin
          state_s = ST_POP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_POP:  state_s = ST_WAIT;
      ST_WAIT: state_s = ST_SEND;
      ST_SEND: begin
        if (last_byte_s) begin
          state_s = arb_valid_s ? ST_POP : ST_IDLE;
        end else begin
          state_s = ST_SEND;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, grant bookkeeping and the word shift register.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_r     <= ST_IDLE;
      grant_r     <= CH_09;
      grant_cnt_r <= 4'd0;
      shreg_r     <= 32'd0;
      byte_idx_r  <= 2'd0;
    end else begin
      state_r <= state_s;
      // The quota counts words started on the current grant and restarts on a channel switch.
      if (arb_take_s) begin
        grant_r     <= arb_gnt_s;
        grant_cnt_r <= (arb_gnt_s == grant_r) ? grant_cnt_r : 4'd0;
      end else if (state_r == ST_WAIT) begin
        grant_cnt_r <= sat_inc(grant_cnt_r, 4'(WORDS_PER_GRANT));
      end else begin
        grant_cnt_r <= grant_cnt_r;
      end
      if (state_r == ST_WAIT) begin
        shreg_r    <= (grant_r == CH_24) ? i_ch1_data : i_ch0_data;
        byte_idx_r <= 2'd0;
      end else if (accept_s) begin
        shreg_r    <= {shreg_r[23:0], 8'h00};
        byte_idx_r <= byte_idx_r + 2'd1;
      end else begin
        shreg_r    <= shreg_r;
        byte_idx_r <= byte_idx_r;
      end
    end
  end

  assign o_ch0_pop   = (state_r == ST_POP) & (grant_r == CH_09);
  assign o_ch1_pop   = (state_r == ST_POP) & (grant_r == CH_24);
  assign o_smi_valid = (state_r == ST_SEND);
  assign o_smi_data  = (state_r == ST_SEND) ? shreg_r[31:24] : 8'h00;
  assign o_smi_sof   = (state_r == ST_SEND) & (byte_idx_r == 2'd0);
  assign o_smi_chan  = (state_r == ST_SEND) & grant_r;
  assign o_busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_rx_stream_arbiter.sv
// Scoreboard bench for rx_stream_arbiter: FIFO models feed the DUT, expected bytes are queued
// as stimulus is loaded and compared as the SMI side accepts them.
module tb_rx_stream_arbiter;

  logic        i_sys_clk;
  logic        i_rst_b;
  logic [1:0]  i_chan_en;
  logic        i_fixed_prio;
  logic        i_ch0_empty;
  logic        o_ch0_pop;
  logic [31:0] i_ch0_data;
  logic        i_ch1_empty;
  logic        o_ch1_pop;
  logic [31:0] i_ch1_data;
  logic [7:0]  o_smi_data;
  logic        o_smi_valid;
  logic        i_smi_ready;
  logic        o_smi_sof;
  logic        o_smi_chan;
  logic        o_busy;

  rx_stream_arbiter #(.WORDS_PER_GRANT(4)) dut (
    .i_sys_clk    (i_sys_clk),
    .i_rst_b      (i_rst_b),
    .i_chan_en    (i_chan_en),
    .i_fixed_prio (i_fixed_prio),
    .i_ch0_empty  (i_ch0_empty),
    .o_ch0_pop    (o_ch0_pop),
    .i_ch0_data   (i_ch0_data),
    .i_ch1_empty  (i_ch1_empty),
    .o_ch1_pop    (o_ch1_pop),
    .i_ch1_data   (i_ch1_data),
    .o_smi_data   (o_smi_data),
    .o_smi_valid  (o_smi_valid),
    .i_smi_ready  (i_smi_ready),
    .o_smi_sof    (o_smi_sof),
    .o_smi_chan   (o_smi_chan),
    .o_busy       (o_busy)
  );

  initial i_sys_clk = 1'b0;
  always #5 i_sys_clk = ~i_sys_clk;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] ch0_q[$];
  logic [31:0] ch1_q[$];
  logic [9:0]  exp_q[$];
  int          cyc = 0;
  int          acc_cnt = 0;
  int          n_pop0 = 0;
  int          n_pop1 = 0;
  bit          prev_stall = 1'b0;
  logic [10:0] prev_bus = 11'd0;
  bit          toggle_rdy = 1'b0;
  bit          wait_first = 1'b0;
  int          t0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [31:0] outs_all();
    return 32'({o_ch0_pop, o_ch1_pop, o_smi_data, o_smi_valid, o_smi_sof, o_smi_chan, o_busy});
  endfunction

  function automatic logic [31:0] word_of(input bit ch, input int i);
    return ch ? (32'hB0B1B200 + 32'(i)) : (32'h0C0D0E00 + 32'(i));
  endfunction

  task automatic update_empty();
    i_ch0_empty = (ch0_q.size() == 0);
    i_ch1_empty = (ch1_q.size() == 0);
  endtask

  task automatic expect_word(input bit ch, input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back({ch, 1'(b == 0), w[31-8*b -: 8]});
    end
  endtask

  task automatic push(input bit ch, input logic [31:0] w, input bit expect_it);
    if (ch) ch1_q.push_back(w);
    else    ch0_q.push_back(w);
    update_empty();
    if (expect_it) expect_word(ch, w);
  endtask

  // One clock: check bus/pops before the edge, then advance the FIFO models after it.
  task automatic tick();
    logic [9:0] e;
    bit pop0;
    bit pop1;
    #1;
    if (prev_stall) begin
      chk("hold", 32'({o_smi_valid, o_smi_chan, o_smi_sof, o_smi_data}), 32'(prev_bus));
    end
    if (wait_first && o_smi_valid) begin
      chk("t2_latency", 32'(cyc - t0), 32'd3);
      wait_first = 1'b0;
    end
    if (o_smi_valid && i_smi_ready) begin
      chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("byte", 32'({o_smi_chan, o_smi_sof, o_smi_data}), 32'(e));
      end
      acc_cnt++;
    end
    prev_stall = o_smi_valid & ~i_smi_ready;
    prev_bus   = {o_smi_valid, o_smi_chan, o_smi_sof, o_smi_data};
    if (o_ch0_pop || o_ch1_pop) begin
      chk("pop_excl", 32'(o_ch0_pop & o_ch1_pop), 32'd0);
      chk("pop_nonempty", 32'((o_ch0_pop & i_ch0_empty) | (o_ch1_pop & i_ch1_empty)), 32'd0);
    end
    pop0 = o_ch0_pop;
    pop1 = o_ch1_pop;
    @(posedge i_sys_clk);
    #1;
    cyc++;
    if (pop0) begin
      n_pop0++;
      if (ch0_q.size() != 0) i_ch0_data = ch0_q.pop_front();
    end
    if (pop1) begin
      n_pop1++;
      if (ch1_q.size() != 0) i_ch1_data = ch1_q.pop_front();
    end
    update_empty();
    if (toggle_rdy) i_smi_ready = ~i_smi_ready;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int i = 0;
    while (i < max_cyc && (exp_q.size() != 0 || o_busy)) begin
      tick();
      i++;
    end
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_idle"}, 32'(o_busy), 32'd0);
  endtask

  task automatic do_reset();
    i_rst_b = 1'b0;
    ch0_q.delete();
    ch1_q.delete();
    exp_q.delete();
    update_empty();
    prev_stall = 1'b0;
    repeat (3) @(posedge i_sys_clk);
    #1;
    i_rst_b = 1'b1;
  endtask

  initial begin
    int start;
    i_rst_b      = 1'b0;
    i_chan_en    = 2'b11;
    i_fixed_prio = 1'b0;
    i_ch0_data   = 32'd0;
    i_ch1_data   = 32'd0;
    i_smi_ready  = 1'b1;
    update_empty();
    #2;
    chk("reset_outs", outs_all(), 32'd0);
    do_reset();

    // Empty FIFOs with both channels enabled: nothing moves.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t1_idle_outs", outs_all(), 32'd0);
    end

    // Single word on ch0.
    n_pop0 = 0;
    t0 = cyc;
    wait_first = 1'b1;
    push(1'b0, 32'hA1B2C3D4, 1'b1);
    drain("t2", 40);
    chk("t2_pops", 32'(n_pop0), 32'd1);
    chk("t2_latency_seen", 32'(wait_first), 32'd0);

    // Both channels loaded, round-robin with a quota of four words.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push(1'b0, word_of(1'b0, i), 1'b0);
      push(1'b1, word_of(1'b1, i), 1'b0);
    end
    for (int blk = 0; blk < 4; blk++) begin
      for (int j = 0; j < 4; j++) begin
        expect_word(blk[0], word_of(blk[0], (blk / 2) * 4 + j));
      end
    end
    drain("t3_rr", 400);

    // Same load with fixed priority: all ch0 words come first.
    do_reset();
    i_fixed_prio = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(1'b0, word_of(1'b0, i), 1'b0);
      push(1'b1, word_of(1'b1, i), 1'b0);
    end
    for (int i = 0; i < 8; i++) expect_word(1'b0, word_of(1'b0, i));
    for (int i = 0; i < 8; i++) expect_word(1'b1, word_of(1'b1, i));
    drain("t3_fixed", 400);
    i_fixed_prio = 1'b0;

    // Ready toggling every cycle: each byte must hold while stalled.
    do_reset();
    toggle_rdy = 1'b1;
    push(1'b0, 32'h01020304, 1'b1);
    drain("t4", 80);
    toggle_rdy  = 1'b0;
    i_smi_ready = 1'b1;

    // ch1 disabled; ch0 enable dropped mid-word.
    do_reset();
    i_chan_en = 2'b01;
    n_pop0 = 0;
    n_pop1 = 0;
    push(1'b1, 32'hDEADBEEF, 1'b0);
    push(1'b0, 32'h11223344, 1'b1);
    push(1'b0, 32'h55AA55AA, 1'b0);
    start = acc_cnt;
    for (int i = 0; i < 50 && acc_cnt < start + 2; i++) tick();
    chk("t5_two_bytes", 32'(acc_cnt - start), 32'd2);
    i_chan_en = 2'b00;
    drain("t5", 40);
    repeat (5) tick();
    chk("t5_ch1_pops", 32'(n_pop1), 32'd0);
    chk("t5_ch0_pops", 32'(n_pop0), 32'd1);
    chk("t5_ch0_left", 32'(ch0_q.size()), 32'd1);
    chk("t5_busy", 32'(o_busy), 32'd0);
    i_chan_en = 2'b11;

    // Reset while byte 2 is on the bus, then resume cleanly.
    do_reset();
    push(1'b0, 32'h55667788, 1'b1);
    start = acc_cnt;
    for (int i = 0; i < 50 && acc_cnt < start + 2; i++) tick();
    chk("t6_two_bytes", 32'(acc_cnt - start), 32'd2);
    #3;
    i_rst_b = 1'b0;
    #1;
    chk("t6_async_outs", outs_all(), 32'd0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(posedge i_sys_clk);
    @(posedge i_sys_clk);
    #1;
    i_rst_b = 1'b1;
    n_pop0 = 0;
    push(1'b0, 32'h99ABCDEF, 1'b1);
    push(1'b0, 32'h0F1E2D3C, 1'b1);
    drain("t6", 80);
    chk("t6_pops", 32'(n_pop0), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
